// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order tag allocation, NUM_WB-port writeback and up to COMMIT_W
// in-order retirements per cycle, with branch resolution and a single-cycle flush at commit.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int DATA_W   = 32,
  parameter int NUM_WB   = 3,
  parameter int COMMIT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic [4:0]                 alloc_rd,
  input  logic                       alloc_has_rd,
  input  logic                       alloc_is_br,
  input  logic                       alloc_pred_taken,
  input  logic [DATA_W-1:0]          alloc_pred_target,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_WB-1:0]          wb_taken,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W*5-1:0]      commit_rd,
  output logic [COMMIT_W-1:0]        commit_has_rd,
  output logic [COMMIT_W*DATA_W-1:0] commit_data,
  output logic [COMMIT_W*TAG_W-1:0]  commit_tag,
  output logic                       br_update_valid,
  output logic [DATA_W-1:0]          br_update_pc,
  output logic                       br_update_taken,
  output logic                       flush_valid,
  output logic [DATA_W-1:0]          flush_pc,
  output logic [TAG_W:0]             count
);
  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]  has_rd_q, has_rd_d, is_br_q, is_br_d;
  logic [DEPTH-1:0]  pred_taken_q, pred_taken_d, act_taken_q, act_taken_d;
  logic [4:0]        rd_q [DEPTH];
  logic [4:0]        rd_d [DEPTH];
  logic [DATA_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] pc_d [DEPTH];
  logic [DATA_W-1:0] pred_target_q [DEPTH];
  logic [DATA_W-1:0] pred_target_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic             full;
  logic [PTR_W-1:0] retire_cnt;
  logic [TAG_W-1:0] sel_idx, wb_idx, clr_idx, alloc_idx;
  logic             sel_stop, mispredict;

  assign full        = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign alloc_ready = ~full & ~flush_valid;
  assign alloc_tag   = tail_q[TAG_W-1:0];
  assign count       = tail_q - head_q;

  // Commit selection from registered state; a retiring branch ends the group.
  always_comb begin
    commit_valid    = '0;
    commit_rd       = '0;
    commit_has_rd   = '0;
    commit_data     = '0;
    commit_tag      = '0;
    br_update_valid = 1'b0;
    br_update_pc    = '0;
    br_update_taken = 1'b0;
    flush_valid     = 1'b0;
    flush_pc        = '0;
    retire_cnt      = '0;
    sel_idx         = '0;
    mispredict      = 1'b0;
    sel_stop        = rst;
    for (int k = 0; k < COMMIT_W; k++) begin
      sel_idx = head_q[TAG_W-1:0] + TAG_W'(k);
      if (!sel_stop && valid_q[sel_idx] && done_q[sel_idx]) begin
        commit_valid[k]                = 1'b1;
        commit_rd[k*5 +: 5]            = rd_q[sel_idx];
        commit_has_rd[k]               = has_rd_q[sel_idx];
        commit_data[k*DATA_W +: DATA_W] = data_q[sel_idx];
        commit_tag[k*TAG_W +: TAG_W]   = sel_idx;
        retire_cnt                     = retire_cnt + PTR_W'(1);
        if (is_br_q[sel_idx]) begin
          sel_stop        = 1'b1;
          mispredict      = (act_taken_q[sel_idx] != pred_taken_q[sel_idx]) ||
                            (act_taken_q[sel_idx] && (data_q[sel_idx] != pred_target_q[sel_idx]));
          br_update_valid = 1'b1;
          br_update_pc    = pc_q[sel_idx];
          br_update_taken = act_taken_q[sel_idx];
          flush_valid     = mispredict;
          if (mispredict) begin
            flush_pc = act_taken_q[sel_idx] ? data_q[sel_idx] : pc_q[sel_idx] + DATA_W'(4);
          end else begin
            flush_pc = '0;
          end
        end else begin
          sel_stop = 1'b0;
        end
      end else begin
        sel_stop = 1'b1;
      end
    end
  end

  // Next-state: writeback, retirement, allocation, then flush overrides validity and tail.
  always_comb begin
    head_d        = head_q + retire_cnt;
    tail_d        = tail_q;
    valid_d       = valid_q;
    done_d        = done_q;
    has_rd_d      = has_rd_q;
    is_br_d       = is_br_q;
    pred_taken_d  = pred_taken_q;
    act_taken_d   = act_taken_q;
    rd_d          = rd_q;
    pc_d          = pc_q;
    pred_target_d = pred_target_q;
    data_d        = data_q;
    wb_idx        = '0;
    clr_idx       = '0;
    alloc_idx     = tail_q[TAG_W-1:0];
    // Ascending port order lets the highest port win a same-tag collision.
    for (int p = 0; p < NUM_WB; p++) begin
      wb_idx = wb_tag[p*TAG_W +: TAG_W];
      if (wb_valid[p] && valid_q[wb_idx]) begin
        done_d[wb_idx]      = 1'b1;
        data_d[wb_idx]      = wb_data[p*DATA_W +: DATA_W];
        act_taken_d[wb_idx] = wb_taken[p];
      end else begin
        done_d[wb_idx] = done_d[wb_idx];
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      clr_idx = head_q[TAG_W-1:0] + TAG_W'(k);
      if (commit_valid[k]) begin
        valid_d[clr_idx] = 1'b0;
      end else begin
        valid_d[clr_idx] = valid_d[clr_idx];
      end
    end
    if (alloc_valid && alloc_ready) begin
      valid_d[alloc_idx]       = 1'b1;
      done_d[alloc_idx]        = 1'b0;
      has_rd_d[alloc_idx]      = alloc_has_rd;
      is_br_d[alloc_idx]       = alloc_is_br;
      pred_taken_d[alloc_idx]  = alloc_pred_taken;
      rd_d[alloc_idx]          = alloc_rd;
      pc_d[alloc_idx]          = alloc_pc;
      pred_target_d[alloc_idx] = alloc_pred_target;
      tail_d                   = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (flush_valid) begin
      valid_d = '0;
      tail_d  = head_d;
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Entry payload; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    has_rd_q      <= has_rd_d;
    is_br_q       <= is_br_d;
    pred_taken_q  <= pred_taken_d;
    act_taken_q   <= act_taken_d;
    rd_q          <= rd_d;
    pc_q          <= pc_d;
    pred_target_q <= pred_target_d;
    data_q        <= data_d;
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed vector table, hand sequences for
// fill/wrap/mispredict, and random traffic against a queue-based reference model.
module tb_rob_multi_commit;
  localparam int DEPTH = 16, TAG_W = 4, DATA_W = 32, NUM_WB = 3, COMMIT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready, alloc_has_rd, alloc_is_br, alloc_pred_taken;
  logic [DATA_W-1:0] alloc_pc, alloc_pred_target;
  logic [4:0] alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic [NUM_WB-1:0] wb_valid, wb_taken;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [COMMIT_W-1:0] commit_valid, commit_has_rd;
  logic [COMMIT_W*5-1:0] commit_rd;
  logic [COMMIT_W*DATA_W-1:0] commit_data;
  logic [COMMIT_W*TAG_W-1:0] commit_tag;
  logic br_update_valid, br_update_taken, flush_valid;
  logic [DATA_W-1:0] br_update_pc, flush_pc;
  logic [TAG_W:0] count;

  always #5 clk = ~clk;

  rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
    .alloc_has_rd(alloc_has_rd), .alloc_is_br(alloc_is_br), .alloc_pred_taken(alloc_pred_taken),
    .alloc_pred_target(alloc_pred_target), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_taken(wb_taken),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_has_rd(commit_has_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .br_update_valid(br_update_valid), .br_update_pc(br_update_pc), .br_update_taken(br_update_taken),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rd;
    logic              has_rd, is_br, pred_taken, done, act_taken;
    logic [DATA_W-1:0] pred_target, data;
  } ent_t;

  ent_t mq[$];
  int next_tag = 0;
  int head_tag = 0;
  int e_n;
  logic [COMMIT_W-1:0] e_cv;
  logic e_bv, e_btk, e_fv;
  logic [DATA_W-1:0] e_bpc, e_fpc;

  function automatic void compute_exp();
    ent_t e;
    e_cv = '0; e_n = 0; e_bv = 1'b0; e_btk = 1'b0; e_fv = 1'b0; e_bpc = '0; e_fpc = '0;
    if (!rst) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (k >= mq.size()) break;
        e = mq[k];
        if (!e.done) break;
        e_cv[k] = 1'b1;
        e_n++;
        if (e.is_br) begin
          e_bv = 1'b1; e_bpc = e.pc; e_btk = e.act_taken;
          if ((e.act_taken != e.pred_taken) || (e.act_taken && e.data != e.pred_target)) begin
            e_fv  = 1'b1;
            e_fpc = e.act_taken ? e.data : e.pc + 32'd4;
          end
          break;
        end
      end
    end
  endfunction

  task automatic model_update(input logic rdy);
    ent_t e;
    if (rst) begin
      mq.delete(); next_tag = 0; head_tag = 0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p]) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == wb_tag[p*TAG_W +: TAG_W]) begin
              e = mq[i]; e.done = 1'b1; e.data = wb_data[p*DATA_W +: DATA_W]; e.act_taken = wb_taken[p];
              mq[i] = e;
            end
          end
        end
      end
      for (int k = 0; k < e_n; k++) void'(mq.pop_front());
      head_tag = (head_tag + e_n) % DEPTH;
      if (e_fv) begin
        mq.delete(); next_tag = head_tag;
      end
      if (alloc_valid && rdy) begin
        e.tag = TAG_W'(next_tag); e.pc = alloc_pc; e.rd = alloc_rd; e.has_rd = alloc_has_rd;
        e.is_br = alloc_is_br; e.pred_taken = alloc_pred_taken; e.pred_target = alloc_pred_target;
        e.done = 1'b0; e.act_taken = 1'b0; e.data = '0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  endtask

  // One cycle: compare outputs against the model, clock, advance the model.
  task automatic tick();
    logic rdy;
    #1;
    compute_exp();
    rdy = (mq.size() < DEPTH) && !e_fv;
    check("count", count, mq.size());
    check("alloc_tag", alloc_tag, next_tag);
    check("alloc_ready", alloc_ready, rdy);
    check("commit_valid", commit_valid, e_cv);
    for (int k = 0; k < COMMIT_W; k++) begin
      if (e_cv[k]) begin
        check("commit_tag", commit_tag[k*TAG_W +: TAG_W], mq[k].tag);
        check("commit_rd", commit_rd[k*5 +: 5], mq[k].rd);
        check("commit_has_rd", commit_has_rd[k], mq[k].has_rd);
        if (!mq[k].is_br) check("commit_data", commit_data[k*DATA_W +: DATA_W], mq[k].data);
      end
    end
    check("br_update_valid", br_update_valid, e_bv);
    if (e_bv) begin
      check("br_update_pc", br_update_pc, e_bpc);
      check("br_update_taken", br_update_taken, e_btk);
    end
    check("flush_valid", flush_valid, e_fv);
    if (e_fv) check("flush_pc", flush_pc, e_fpc);
    @(posedge clk);
    model_update(rdy);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_pc = '0; alloc_rd = '0; alloc_has_rd = 1'b0; alloc_is_br = 1'b0;
    alloc_pred_taken = 1'b0; alloc_pred_target = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_taken = '0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic is_br,
                           input logic ptk, input logic [31:0] ptgt);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_rd = rd; alloc_has_rd = !is_br; alloc_is_br = is_br;
    alloc_pred_taken = ptk; alloc_pred_target = ptgt;
  endtask

  task automatic set_wb(input int p, input logic [3:0] tag, input logic [31:0] d, input logic tk);
    wb_valid[p] = 1'b1; wb_tag[p*TAG_W +: TAG_W] = tag; wb_data[p*DATA_W +: DATA_W] = d; wb_taken[p] = tk;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  typedef struct {
    logic av, abr;
    logic [31:0] atgt;
    logic [2:0] wv, wtk;
    logic [11:0] wt;
    logic [95:0] wd;
    logic [4:0] ec;
    logic [1:0] ecv, edchk;
    logic [31:0] ecd0, ecd1;
    logic ebv;
  } vec_t;

  function automatic vec_t mkv(input logic av, input logic abr, input logic [31:0] atgt,
      input logic [2:0] wv, input logic [11:0] wt, input logic [95:0] wd, input logic [2:0] wtk,
      input logic [4:0] ec, input logic [1:0] ecv, input logic [1:0] edchk,
      input logic [31:0] ecd0, input logic [31:0] ecd1, input logic ebv);
    vec_t v;
    v.av = av; v.abr = abr; v.atgt = atgt; v.wv = wv; v.wt = wt; v.wd = wd; v.wtk = wtk;
    v.ec = ec; v.ecv = ecv; v.edchk = edchk; v.ecd0 = ecd0; v.ecd1 = ecd1; v.ebv = ebv;
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    ent_t e;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_br_update_valid", br_update_valid, 0);
    check("rst_flush_valid", flush_valid, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_flush_pc", flush_pc, 0);

    // Out-of-order writeback, same-tag collision, stray tag, correctly predicted branch.
    tbl[0]  = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[2]  = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 2, 2'b00, 2'b00, 0, 0, 0);
    tbl[3]  = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 3, 2'b00, 2'b00, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 0, 3'b001, 12'h003, {32'h0, 32'h0, 32'h33}, 3'b000, 4, 2'b00, 2'b00, 0, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 3'b010, 12'h010, {32'h0, 32'h11, 32'h0}, 3'b000, 4, 2'b00, 2'b00, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0, 3'b101, 12'h200, {32'h22, 32'h0, 32'h10}, 3'b000, 4, 2'b00, 2'b00, 0, 0, 0);
    tbl[7]  = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 4, 2'b11, 2'b11, 32'h10, 32'h11, 0);
    tbl[8]  = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 2, 2'b11, 2'b11, 32'h22, 32'h33, 0);
    tbl[9]  = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[10] = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[11] = mkv(0, 0, 0, 3'b111, 12'h474, {32'hB, 32'hDEAD, 32'hA}, 3'b000, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[12] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b01, 2'b01, 32'hB, 0, 0);
    tbl[13] = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[14] = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[15] = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 2, 2'b00, 2'b00, 0, 0, 0);
    tbl[16] = mkv(0, 0, 0, 3'b111, 12'h765, {32'h77, 32'h66, 32'h55}, 3'b000, 3, 2'b00, 2'b00, 0, 0, 0);
    tbl[17] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 3, 2'b11, 2'b11, 32'h55, 32'h66, 0);
    tbl[18] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b01, 2'b01, 32'h77, 0, 0);
    tbl[19] = mkv(1, 1, 32'h400, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[20] = mkv(1, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b00, 2'b00, 0, 0, 0);
    tbl[21] = mkv(0, 0, 0, 3'b011, 12'h098, {32'h0, 32'h99, 32'h400}, 3'b001, 2, 2'b00, 2'b00, 0, 0, 0);
    tbl[22] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 2, 2'b01, 2'b00, 0, 0, 1);
    tbl[23] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 1, 2'b01, 2'b01, 32'h99, 0, 0);
    tbl[24] = mkv(0, 0, 0, 3'b000, 12'h000, 96'h0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      idle();
      if (tbl[i].av) set_alloc(32'h1000 + 32'(i * 4), 5'(i), tbl[i].abr, tbl[i].abr, tbl[i].atgt);
      wb_valid = tbl[i].wv; wb_tag = tbl[i].wt; wb_data = tbl[i].wd; wb_taken = tbl[i].wtk;
      #1;
      check("tbl_count", count, tbl[i].ec);
      check("tbl_commit_valid", commit_valid, tbl[i].ecv);
      check("tbl_br_update_valid", br_update_valid, tbl[i].ebv);
      check("tbl_flush_valid", flush_valid, 0);
      if (tbl[i].edchk[0]) check("tbl_commit_data0", commit_data[31:0], tbl[i].ecd0);
      if (tbl[i].edchk[1]) check("tbl_commit_data1", commit_data[63:32], tbl[i].ecd1);
      tick();
    end

    // Fill to capacity; the 17th offer must be refused.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      idle();
      set_alloc(32'h2000 + 32'(4 * i), 5'(i), 1'b0, 1'b0, 32'h0);
      check("fill_tag", alloc_tag, (i < 16) ? i : 0);
      check("fill_ready", alloc_ready, (i < 16));
      tick();
    end
    check("fill_count", count, 16);
    check("fill_tag_after", alloc_tag, 0);

    // Retire ten, reallocate ten across the wrap, then drain across index 15 -> 0.
    for (int j = 0; j < 10; j++) begin
      if (j % 3 == 0) idle();
      set_wb(j % 3, 4'(j), 32'hA000 + 32'(j), 1'b0);
      if (j % 3 == 2 || j == 9) tick();
    end
    for (int c = 0; c < 20 && count != 5'd6; c++) begin
      idle(); tick();
    end
    check("wrap_count_partial", count, 6);
    for (int i = 0; i < 10; i++) begin
      idle();
      set_alloc(32'h5000 + 32'(4 * i), 5'(i + 3), 1'b0, 1'b0, 32'h0);
      check("wrap_tag", alloc_tag, i);
      tick();
    end
    check("wrap_count_full", count, 16);
    for (int j = 0; j < 16; j++) begin
      if (j % 3 == 0) idle();
      set_wb(j % 3, 4'((10 + j) % 16), 32'hB000 + 32'(j), 1'b0);
      if (j % 3 == 2 || j == 15) tick();
    end
    for (int c = 0; c < 20; c++) begin
      idle(); tick();
    end
    check("wrap_count_drained", count, 0);

    // Mispredicted branch at tag 2 retiring alongside tag 1, younger tags 3-5 flushed.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      set_alloc((i == 2) ? 32'h100 : 32'h3000 + 32'(4 * i), 5'(i + 1), (i == 2), 1'b0, 32'h0);
      tick();
    end
    idle(); set_wb(0, 4'd0, 32'h50, 1'b0); tick();
    idle();
    check("mp_first_commit", commit_valid, 2'b01);
    set_wb(0, 4'd1, 32'h51, 1'b0); set_wb(1, 4'd2, 32'h200, 1'b1);
    tick();
    idle(); set_alloc(32'h4000, 5'd9, 1'b0, 1'b0, 32'h0);
    check("mp_commit_valid", commit_valid, 2'b11);
    check("mp_flush_valid", flush_valid, 1);
    check("mp_flush_pc", flush_pc, 32'h200);
    check("mp_br_update_valid", br_update_valid, 1);
    check("mp_br_update_pc", br_update_pc, 32'h100);
    check("mp_alloc_ready", alloc_ready, 0);
    tick();
    idle();
    check("mp_count_after", count, 0);
    check("mp_tag_after", alloc_tag, 3);
    tick();

    // Random traffic with occasional mid-operation reset.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      if ($urandom_range(0, 9) < 7)
        set_alloc($urandom, 5'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 32'h800 : $urandom);
      for (int p = 0; p < NUM_WB; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          if (mq.size() > 0 && $urandom_range(0, 9) != 0) begin
            e = mq[$urandom_range(0, mq.size() - 1)];
            if (e.is_br && $urandom_range(0, 1) != 0) set_wb(p, e.tag, e.pred_target, e.pred_taken);
            else set_wb(p, e.tag, ($urandom_range(0, 1) != 0) ? e.pred_target : $urandom, 1'($urandom));
          end else begin
            set_wb(p, 4'($urandom), $urandom, 1'($urandom));
          end
        end
      end
      tick();
      rst = 1'b0;
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_multi_commit.md
# rob_multi_commit

Parametrised reorder buffer with multi-port writeback and in-order multi-instruction commit. It sits between dispatch (instruction queue / reservation-station loaders) and the register file / branch predictor. It allocates tags in program order, collects results from `NUM_WB` execution ports and retires up to `COMMIT_W` finished entries per cycle. Branch mispredicts are resolved precisely at commit with a single-cycle flush.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; must be a power of 2, at least 4.
- `TAG_W`, default `$clog2(DEPTH)`: tag width.
- `DATA_W`, default 32: result and PC width.
- `NUM_WB`, default 3: writeback ports.
- `COMMIT_W`, default 2: maximum retirements per cycle; must be at least 1 and no greater than `DEPTH`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `alloc_valid`, in, 1: dispatch offers an instruction.
- `alloc_ready`, out, 1: the buffer can accept an instruction this cycle.
- `alloc_pc`, in, `DATA_W`: instruction PC.
- `alloc_rd`, in, 5: destination register.
- `alloc_has_rd`, in, 1: instruction writes a register (0 for branch and store).
- `alloc_is_br`, in, 1: conditional branch or jalr.
- `alloc_pred_taken`, in, 1: predicted direction.
- `alloc_pred_target`, in, `DATA_W`: predicted target.
- `alloc_tag`, out, `TAG_W`: tag assigned to the instruction (equals tail index).
- `wb_valid`, in, `NUM_WB`: per-port result valid.
- `wb_tag`, in, `NUM_WB*TAG_W`: packed tags, port p at `[p*TAG_W +: TAG_W]`.
- `wb_data`, in, `NUM_WB*DATA_W`: packed results; for branches, the actual target.
- `wb_taken`, in, `NUM_WB`: actual branch direction.
- `commit_valid`, out, `COMMIT_W`: per-slot retire; slot 0 is the oldest; the set bits are always contiguous from bit 0.
- `commit_rd`, out, `COMMIT_W*5`: destination register per slot.
- `commit_has_rd`, out, `COMMIT_W`: register write enable per slot.
- `commit_data`, out, `COMMIT_W*DATA_W`: value to write per slot.
- `commit_tag`, out, `COMMIT_W*TAG_W`: tag per slot.
- `br_update_valid`, out, 1: a branch retires this cycle.
- `br_update_pc`, out, `DATA_W`: PC of that branch.
- `br_update_taken`, out, 1: actual direction of that branch.
- `flush_valid`, out, 1: mispredict flush.
- `flush_pc`, out, `DATA_W`: redirect PC.
- `count`, out, `TAG_W+1`: number of occupied entries.

## Operation
- State: `head` and `tail` are `TAG_W+1`-bit pointers; the MSB is the wrap bit.
  - `count = tail - head`, modulo 2^(TAG_W+1).
  - Empty when `head == tail`.
  - Full when the low bits are equal and the MSBs differ.
- Entry fields: valid, done, pc, rd, has_rd, is_br, pred_taken, pred_target, act_taken, data.
- Allocate:
  - `alloc_ready = ~full & ~flush_valid`.
  - On `alloc_valid & alloc_ready`, write entry `tail[TAG_W-1:0]` with valid=1, done=0, then increment `tail`.
  - `alloc_tag` is always `tail[TAG_W-1:0]`.
- Writeback:
  - For each port with `wb_valid` set whose tagged entry is valid: set done=1 and store data and act_taken.
  - A writeback to an invalid entry is ignored.
  - Two ports writing the same tag in one cycle: the higher port index wins.
- Commit selection, combinational from registered state:
  - Slot k, for k = 0..`COMMIT_W`-1, examines entry `head+k`.
  - Slot k retires if slots 0..k-1 retired, the entry is valid and done, and no earlier slot in this cycle retired a branch.
  - A branch may only be the last retirement of a cycle.
- Branch resolution, for a retiring branch:
  - Assert `br_update_valid`, `br_update_pc` and `br_update_taken`.
  - Mispredict when `act_taken != pred_taken`, or when `act_taken` and `data != pred_target`.
  - On mispredict: `flush_valid = 1`; `flush_pc = act_taken ? data : pc + 4`, modulo 2^`DATA_W`.
  - A non-branch retiring entry drives `commit_data = data`.
- Update at clock edge:
  - `head` advances by the number of retirements.
  - Retired entries get valid=0.
  - On flush: every entry gets valid=0, and `tail` is set to the new `head`.

## Timing
- Reset values:
  - `head = tail = 0`; all valid and done bits 0.
  - Outputs: `alloc_ready = 1`, `alloc_tag = 0`, `count = 0`.
  - All of `commit_valid`, `br_update_valid` and `flush_valid` are 0; data outputs are 0.
- Reset mid-operation discards all entries on the next edge with no commit or flush.
- Latency:
  - Allocation at edge N makes the entry writable from cycle N.
  - Writeback at edge N+1 at the earliest.
  - Commit outputs are visible in cycle N+1 and retire at edge N+2.
- There is no combinational path from `wb_*` to `commit_*`.
- Simultaneous allocate and commit when full: `alloc_ready` is 0 (no same-cycle bypass). The freed slot is usable in the next cycle.
- Flush cycle:
  - Allocation is blocked; writebacks in that cycle are dropped.
  - Older entries retired in the same cycle commit normally.
- Pointer wrap: indices use the low `TAG_W` bits; the wrap bit only distinguishes full from empty.

## Test plan
- Reset, then allocate 16 entries with no writeback: `alloc_tag` goes 0..15, `count` reaches 16, then `alloc_ready` = 0. A 17th offer is not accepted.
- Allocate tags 0–3; write back tag 3, then tag 1, then tags 0 and 2 together on ports 0 and 2: nothing commits until tag 0 is done. The following cycle retires 0 and 1, the next retires 2 and 3, in order with correct data.
- Wrap: fill, retire 10 entries, allocate 10 more: tags go 0..9 again, and commits cross index 15→0 in order; `count` is correct throughout.
- Branch at tag 2 with pc=0x100, pred not-taken, writeback taken with target 0x200, and tags 3–5 allocated:
  - `flush_valid` = 1 and `flush_pc` = 0x200 in the cycle tag 2 retires.
  - The next cycle has `count` = 0 and `alloc_tag` = 3.
- Branch in slot 0 predicted correctly with a done non-branch behind it: only slot 0 retires that cycle, `br_update_valid` = 1, and the younger entry retires the following cycle.
- Same-tag writeback on ports 0 (data 0xA) and 2 (data 0xB): the commit shows 0xB. Writeback to an unallocated tag changes nothing.
